load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Sits between the execute stage and the 64-bit, doubleword-indexed data memory (1024 x 64b).
//  - Accepts byte-addressed RV64 loads and stores (funct3-encoded size and sign).
//  - Converts each byte address to a doubleword index.
//  - Performs sub-doubleword stores as read-modify-write, because the memory has no byte enables.
//  - Aligns and sign/zero-extends load data.
//  - Flags misaligned or illegal accesses without touching memory.
// PARAMETERS
//  XLEN       64    data/address width
//  MEM_DEPTH  1024  doubleword entries in data memory (used by range check)
// PORTS
//  clk          in   1     single clock; all state on posedge
//  rst_n        in   1     reset; asynchronous, active-low
//  req_valid    in   1     request present
//  req_ready    out  1     = (state==IDLE) & rst_n; transfer on req_valid & req_ready
//  req_write    in   1     1 = store, 0 = load
//  req_funct3   in   3     RV64 funct3 (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD)
//  req_addr     in   XLEN  byte address
//  req_wdata    in   XLEN  store data (low bytes used for SB/SH/SW)
//  resp_valid   out  1     one-cycle completion pulse; no backpressure
//  resp_rdata   out  XLEN  extended load data; 0 for stores and errors
//  resp_err     out  1     valid with resp_valid: misaligned/illegal/out-of-range
//  mem_addr     out  XLEN  doubleword index = req_addr >> 3 (zero-extended)
//  mem_wdata    out  XLEN  full doubleword to write
//  mem_we       out  1     memory write enable (MemWrite)
//  mem_re       out  1     memory read enable (MemRead); read data valid next cycle
//  mem_rdata    in   XLEN  registered memory read data
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0.
//   - mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0; request latches cleared.
//  Accept: request fields latch on the accepting edge; req_ready is 0 in every state except IDLE.
//  FSM states: IDLE, RD, MRG, WR, RESP.
//   - Legal load:             IDLE -> RD (mem_re=1) -> MRG (capture + align mem_rdata) -> RESP
//   - Store SD:               IDLE -> WR (mem_we=1, mem_wdata=req_wdata) -> RESP
//   - Store SB/SH/SW:         IDLE -> RD -> MRG (merge bytes into write buffer) -> WR -> RESP
//   - Error:                  IDLE -> RESP (resp_err=1); mem_re/mem_we never asserted
//   - RESP -> IDLE unconditionally.
//  Latency (accept edge = edge 0; resp_valid is high in the cycle after edge N):
//   - Load: N=3.  SD: N=2.  Partial store: N=4.  Error: N=1.
//   - Back-to-back: the next request is accepted in the first IDLE cycle after RESP.
//  Alignment rules:
//   - H requires addr[0]=0; W requires addr[1:0]=0; D requires addr[2:0]=0.
//   - Aligned accesses therefore never cross a doubleword.
//  Byte lane selection: lane = addr[2:0].
//   - Loads: select lanes, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU).
//  Illegal funct3 (error): load 3'b111; store funct3[2]=1.
//  mem_we and mem_re are never asserted in the same cycle.
//  Reset mid-operation: immediate return to IDLE; pending op dropped.
//   - mem_we drops asynchronously, so no write occurs on the following edge.
//   - A write completed on an earlier edge stays in memory.
// CONFIGURATION
//  LSU_RANGE_CHECK_EN defined:
//   - A legal request with addr[63:3] >= MEM_DEPTH takes the error path (resp_err=1).
//   - No memory access occurs for it.
//  LSU_RANGE_CHECK_EN undefined: no range check; mem_addr is passed through unchecked.
// STRUCTURE
//  - lsu_pkg: funct3 localparams, state encoding, XLEN.
//  - Sub-module lsu_align (combinational): load extract/extend and store byte merge.
//  - Top level holds the FSM, request latches and the response register.
// TESTING (mem[0] preloaded 0x8877665544332211)
//  1. LB 0x7 -> 0xFFFFFFFFFFFFFF88; LBU 0x7 -> 0x88; resp_valid exactly 3 cycles after accept.
//  2. LH 0x6 -> 0xFFFFFFFFFFFF8877; LW 0x4 -> 0xFFFFFFFF88776655; LWU 0x4 -> 0x88776655.
//  3. SB 0x1, wdata 0xAB -> mem[0]=0x887766554433AB11; mem_we high exactly 1 cycle; resp at +4.
//  4. SD 0x8, wdata 0x0123456789ABCDEF -> mem[1] written; mem_re never high; resp at +2.
//  5. LW 0x2 -> resp_err=1 at +1, no mem_re/mem_we; load funct3=3'b111 -> err; req_ready 0 while busy.
//  6. rst_n low during MRG of SB -> mem[0] unchanged, outputs at reset values.
//     With LSU_RANGE_CHECK_EN: LD 0x2000 -> err; without the macro: mem_addr=1024 is issued.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 codes, FSM states,
// latched request record and the alignment/legality check.
package lsu_pkg;

  localparam int XLEN      = 64;
  localparam int MEM_DEPTH = 1024;
  localparam int NUM_LANES = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {IDLE, RD, MRG, WR, RESP} state_t;

  typedef struct packed {
    logic            write;
    logic [2:0]      funct3;
    logic [2:0]      lane;
    logic [XLEN-1:0] wdata;
  } req_t;

  // Illegal encoding or natural-alignment violation; size is funct3[1:0].
  function automatic logic access_err(input logic write, input logic [2:0] funct3,
                                      input logic [2:0] lane);
    logic illegal;
    logic misal;
    illegal = write ? funct3[2] : (funct3 == 3'b111);
    case (funct3[1:0])
      F3_B[1:0]: misal = 1'b0;
      F3_H[1:0]: misal = lane[0];
      F3_W[1:0]: misal = |lane[1:0];
      default:   misal = |lane;
    endcase
    return illegal | misal;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extract + sign/zero extend, and the
// store merge of new bytes into the doubleword read back from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  input  logic [2:0]      lane,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ld_data,
  output logic [XLEN-1:0] st_data
);

  logic                           uns;
  logic [XLEN-1:0]                sh;
  logic [NUM_LANES-1:0]           base, mask;
  logic [NUM_LANES-1:0][7:0]      wsh_b, rd_b, st_b;

  assign uns = funct3[2];
  assign sh  = rdata >> {lane, 3'b000};

  always_comb begin
    ld_data = sh;
    case (funct3[1:0])
      F3_B[1:0]: ld_data = uns ? XLEN'(sh[7:0])  : {{(XLEN-8){sh[7]}},   sh[7:0]};
      F3_H[1:0]: ld_data = uns ? XLEN'(sh[15:0]) : {{(XLEN-16){sh[15]}}, sh[15:0]};
      F3_W[1:0]: ld_data = uns ? XLEN'(sh[31:0]) : {{(XLEN-32){sh[31]}}, sh[31:0]};
      default:   ld_data = sh;
    endcase
  end

  always_comb begin
    base = '1;
    case (funct3[1:0])
      F3_B[1:0]: base = NUM_LANES'(1);
      F3_H[1:0]: base = NUM_LANES'(3);
      F3_W[1:0]: base = NUM_LANES'(15);
      default:   base = '1;
    endcase
  end

  assign mask  = base << lane;
  assign wsh_b = wdata << {lane, 3'b000};
  assign rd_b  = rdata;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign st_b[i] = mask[i] ? wsh_b[i] : rd_b[i];
  end

  assign st_data = st_b;

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store unit in front of a doubleword-wide memory without byte enables.
// Optional macro LSU_RANGE_CHECK_EN: send out-of-range doubleword indices to the error path.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  output logic            mem_re,
  input  logic [XLEN-1:0] mem_rdata
);

  state_t          state, state_nxt;
  req_t            q;
  logic            err_q;
  logic [XLEN-1:0] ld_q, ld_data, st_data;
  logic            acc, range_err, err_now;

`ifdef LSU_RANGE_CHECK_EN
  assign range_err = (req_addr >> 3) >= XLEN'(MEM_DEPTH);
`else
  assign range_err = 1'b0;
`endif

  assign acc       = req_valid & req_ready;
  assign err_now   = access_err(req_write, req_funct3, req_addr[2:0]) | range_err;
  assign req_ready = (state == IDLE) & rst_n;
  // Decoded from state so the async reset kills a pending write immediately.
  assign mem_re    = (state == RD);
  assign mem_we    = (state == WR);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (acc) begin
        if (err_now)                                        state_nxt = RESP;
        else if (req_write && req_funct3[1:0] == F3_D[1:0]) state_nxt = WR;
        else                                                state_nxt = RD;
      end
      RD:      state_nxt = MRG;
      MRG:     state_nxt = q.write ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  lsu_align u_align (
    .rdata   (mem_rdata),
    .wdata   (q.wdata),
    .lane    (q.lane),
    .funct3  (q.funct3),
    .ld_data (ld_data),
    .st_data (st_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      q          <= '0;
      err_q      <= 1'b0;
      ld_q       <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        q        <= '{write: req_write, funct3: req_funct3, lane: req_addr[2:0], wdata: req_wdata};
        err_q    <= err_now;
        mem_addr <= {3'b000, req_addr[XLEN-1:3]};
        if (req_write) mem_wdata <= req_wdata;
      end
      if (state == MRG) begin
        if (q.write) mem_wdata <= st_data;
        else         ld_q      <= ld_data;
      end
      resp_valid <= (state == RESP);
      resp_err   <= (state == RESP) & err_q;
      resp_rdata <= (state == RESP && !err_q && !q.write) ? ld_q : '0;
    end
  end

endmodule
